// File: rtl/lif_pkg.sv
// Shared definitions for the LIF step controller and the neuron bench.
// NRN_STEP_INIT is the neuron's step counter value when a window opens.
package lif_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    RESULT,
    END
  } lif_state_e;

  localparam logic [7:0] NRN_STEP_INIT    = 8'd1;
  localparam logic [7:0] DEFAULT_SP_STEPS = 8'd64;

endpackage

// File: rtl/lif_step_timer.sv
// Step strobe generator: one step_en every STEP_GAP+1 cycles until sp_steps strobes are issued.
// start_i fires the first strobe next cycle; dropping run_i kills further strobes.
module lif_step_timer #(
  parameter int STEP_GAP = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic       run_i,
  input  logic [7:0] sp_steps_i,
  output logic       step_en_o,
  output logic       last_step_o
);

  localparam int            GW  = (STEP_GAP > 0) ? $clog2(STEP_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP = GW'(STEP_GAP);

  logic [GW-1:0] gap_q;
  logic [7:0]    cnt_q;
  logic          step_q;
  logic          more;
  logic          fire;

  // cnt_q counts strobes issued so far, including the one currently on step_q
  assign more        = (cnt_q != sp_steps_i);
  assign fire        = run_i && more && (step_q ? (GAP == '0) : (gap_q == GW'(1)));
  assign last_step_o = step_q && !more;
  assign step_en_o   = step_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_q  <= '0;
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else if (start_i) begin
      gap_q  <= '0;
      cnt_q  <= 8'd1;
      step_q <= 1'b1;
    end else begin
      step_q <= fire;
      if (fire) cnt_q <= cnt_q + 8'd1;
      if (step_q) gap_q <= GAP;
      else if (gap_q != '0) gap_q <= gap_q - GW'(1);
    end
  end

endmodule

// File: rtl/lif_step_controller.sv
// Per-pixel sequencer for one LIF neuron: load, step, drain, report one result, close the window.
// One pixel in flight; the result is held until res_ready, abort jumps straight to the close.
module lif_step_controller
  import lif_pkg::*;
#(
  parameter int STEP_GAP     = 0,
  parameter int DRAIN_CYCLES = 2,
  parameter int IDX_W        = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [7:0]       pix_data,
  input  logic [7:0]       cfg_sp_steps,
  input  logic [7:0]       cfg_threshold,
  input  logic             abort,
  output logic [7:0]       nrn_input_current,
  output logic [7:0]       nrn_sp_steps,
  output logic [7:0]       nrn_threshold,
  output logic             nrn_data_en,
  output logic             nrn_step_en,
  output logic             nrn_clear_spike,
  output logic             nrn_end_step,
  input  logic             nrn_spike_out,
  input  logic [7:0]       nrn_step,
  input  logic [7:0]       nrn_spike_count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_count,
  output logic [7:0]       res_events,
  output logic [IDX_W-1:0] res_idx,
  output logic             res_step_err
);

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  lif_state_e       state_q;
  logic             pix_ready_q, data_en_q, clear_q, end_q, spk_prev_q;
  logic             res_valid_q, res_err_q;
  logic [7:0]       cur_q, steps_q, thr_q, ev_q, ev_d, drain_q, res_count_q;
  logic [IDX_W-1:0] idx_q;
  logic             win, spk_edge, abort_act, timer_start, timer_run, last_step;

  assign win         = (state_q == LOAD) || (state_q == RUN) || (state_q == DRAIN);
  assign spk_edge    = win && nrn_spike_out && !spk_prev_q;
  assign ev_d        = (spk_edge && (ev_q != 8'hFF)) ? ev_q + 8'd1 : ev_q;
  assign abort_act   = abort && (win || (state_q == RESULT));
  assign timer_start = (state_q == LOAD) && !abort && (steps_q != 8'd0);
  assign timer_run   = (state_q == RUN) && !abort;

  lif_step_timer #(.STEP_GAP(STEP_GAP)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (timer_start),
    .run_i      (timer_run),
    .sp_steps_i (steps_q),
    .step_en_o  (nrn_step_en),
    .last_step_o(last_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pix_ready_q <= 1'b1;
      data_en_q   <= 1'b0;
      clear_q     <= 1'b0;
      end_q       <= 1'b0;
      spk_prev_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      cur_q       <= '0;
      steps_q     <= '0;
      thr_q       <= '0;
      ev_q        <= '0;
      drain_q     <= '0;
      res_count_q <= '0;
      idx_q       <= '0;
    end else begin
      spk_prev_q <= nrn_spike_out;
      clear_q    <= spk_edge;
      ev_q       <= ev_d;
      end_q      <= 1'b0;
      if (abort_act) begin
        state_q     <= END;
        data_en_q   <= 1'b0;
        res_valid_q <= 1'b0;
        end_q       <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (pix_valid && pix_ready_q) begin
            cur_q       <= pix_data;
            steps_q     <= cfg_sp_steps;
            thr_q       <= cfg_threshold;
            ev_q        <= '0;
            pix_ready_q <= 1'b0;
            data_en_q   <= 1'b1;
            state_q     <= LOAD;
          end
          LOAD: begin
            drain_q <= '0;
            state_q <= (steps_q == 8'd0) ? DRAIN : RUN;
          end
          RUN: if (last_step) begin
            drain_q <= '0;
            state_q <= DRAIN;
          end
          // The neuron's count/step outputs lag the last strobe, so sample only after the drain
          DRAIN: if (drain_q == DRAIN_LAST) begin
            res_count_q <= nrn_spike_count;
            res_err_q   <= (nrn_step != steps_q + NRN_STEP_INIT);
            res_valid_q <= 1'b1;
            state_q     <= RESULT;
          end else begin
            drain_q <= drain_q + 8'd1;
          end
          RESULT: if (res_ready) begin
            res_valid_q <= 1'b0;
            data_en_q   <= 1'b0;
            end_q       <= 1'b1;
            state_q     <= END;
          end
          END: begin
            idx_q       <= idx_q + IDX_W'(1);
            pix_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pix_ready         = pix_ready_q;
  assign nrn_input_current = cur_q;
  assign nrn_sp_steps      = steps_q;
  assign nrn_threshold     = thr_q;
  assign nrn_data_en       = data_en_q;
  assign nrn_clear_spike   = clear_q;
  assign nrn_end_step      = end_q;
  assign res_valid         = res_valid_q;
  assign res_count         = res_count_q;
  assign res_events        = ev_q;
  assign res_idx           = idx_q;
  assign res_step_err      = res_err_q;

endmodule

// File: tb/tb_lif_step_controller.sv
// Bench for lif_step_controller driving a simple integrate-and-fire neuron with a two-stage output delay.
// A second instance with STEP_GAP=2 checks strobe spacing.
module tb_lif_step_controller;
  import lif_pkg::*;

  localparam int DRAIN = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic       pix_valid = 1'b0, pix_valid2 = 1'b0, abort = 1'b0, res_ready = 1'b1;
  logic [7:0] pix_data = '0, cfg_sp_steps = '0, cfg_threshold = '0;
  logic       pix_ready, nrn_data_en, nrn_step_en, nrn_clear_spike, nrn_end_step;
  logic [7:0] nrn_input_current, nrn_sp_steps, nrn_threshold;
  logic       nrn_spike_out, res_valid, res_step_err;
  logic [7:0] nrn_step, nrn_spike_count, res_count, res_events;
  logic [9:0] res_idx;

  logic       pix_ready2, de2, se2, cs2, es2, rv2, err2;
  logic [7:0] cur2, sp2, thr2, rc2, re2;
  logic [9:0] ri2;

  lif_step_controller #(.STEP_GAP(0), .DRAIN_CYCLES(DRAIN), .IDX_W(10)) dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .cfg_sp_steps(cfg_sp_steps), .cfg_threshold(cfg_threshold),
    .abort(abort), .nrn_input_current(nrn_input_current), .nrn_sp_steps(nrn_sp_steps),
    .nrn_threshold(nrn_threshold), .nrn_data_en(nrn_data_en), .nrn_step_en(nrn_step_en),
    .nrn_clear_spike(nrn_clear_spike), .nrn_end_step(nrn_end_step),
    .nrn_spike_out(nrn_spike_out), .nrn_step(nrn_step), .nrn_spike_count(nrn_spike_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
    .res_events(res_events), .res_idx(res_idx), .res_step_err(res_step_err)
  );

  lif_step_controller #(.STEP_GAP(2), .DRAIN_CYCLES(DRAIN), .IDX_W(10)) dut_gap (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid2), .pix_ready(pix_ready2),
    .pix_data(pix_data), .cfg_sp_steps(cfg_sp_steps), .cfg_threshold(cfg_threshold),
    .abort(1'b0), .nrn_input_current(cur2), .nrn_sp_steps(sp2),
    .nrn_threshold(thr2), .nrn_data_en(de2), .nrn_step_en(se2),
    .nrn_clear_spike(cs2), .nrn_end_step(es2),
    .nrn_spike_out(1'b0), .nrn_step(8'd5), .nrn_spike_count(8'd0),
    .res_valid(rv2), .res_ready(1'b1), .res_count(rc2),
    .res_events(re2), .res_idx(ri2), .res_step_err(err2)
  );

  // Neuron model: membrane resets to zero on fire, spike latched until cleared, fire beats clear
  int         mem;
  logic [7:0] m_stp, m_cnt;
  logic       m_spk, de_prev, inj_err = 1'b0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= 0; m_stp <= NRN_STEP_INIT; m_cnt <= '0; m_spk <= 1'b0; de_prev <= 1'b0;
      nrn_step <= '0; nrn_spike_count <= '0;
    end else begin
      de_prev         <= nrn_data_en;
      nrn_step        <= m_stp;
      nrn_spike_count <= m_cnt;
      if (nrn_end_step || (nrn_data_en && !de_prev)) begin
        mem <= 0; m_stp <= inj_err ? 8'd2 : NRN_STEP_INIT; m_cnt <= '0; m_spk <= 1'b0;
      end else begin
        if (nrn_clear_spike) m_spk <= 1'b0;
        if (nrn_step_en) begin
          m_stp <= m_stp + 8'd1;
          if (mem + int'(nrn_input_current) >= int'(nrn_threshold)) begin
            mem <= 0; m_spk <= 1'b1;
            if (m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
          end else begin
            mem <= mem + int'(nrn_input_current);
          end
        end
      end
    end
  end
  assign nrn_spike_out = m_spk;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // clear_spike must follow every in-window rising edge of spike_out by exactly one cycle
  logic mon_prev = 1'b0, mon_pend = 1'b0;
  int   clr_bad = 0, clr_seen = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_prev = 1'b0; mon_pend = 1'b0;
    end else begin
      if (nrn_clear_spike !== mon_pend) clr_bad++;
      if (nrn_clear_spike) clr_seen++;
      mon_pend = nrn_spike_out && !mon_prev && nrn_data_en && !res_valid;
      mon_prev = nrn_spike_out;
    end
  end

  typedef struct {
    logic [7:0] pix, steps, thr;
    logic       inj;
    logic [7:0] cnt, ev;
    logic       err;
  } vec_t;

  typedef struct {
    logic [7:0] cnt, ev;
    logic [9:0] idx;
    logic       err;
  } exp_t;

  vec_t       rows[8];
  exp_t       sb[$];
  logic [9:0] exp_idx = '0;

  function automatic logic [56:0] out_vec();
    return {pix_ready, nrn_input_current, nrn_sp_steps, nrn_threshold, nrn_data_en,
            nrn_step_en, nrn_clear_spike, nrn_end_step, res_valid, res_count,
            res_events, res_idx, res_step_err};
  endfunction

  task automatic send(input logic [7:0] d, input logic [7:0] s, input logic [7:0] t,
                      input logic inj);
    int n;
    n = 0;
    @(negedge clk);
    pix_data = d; cfg_sp_steps = s; cfg_threshold = t; inj_err = inj; pix_valid = 1'b1;
    while (!pix_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 64'(pix_ready), 64'd1);
    @(posedge clk);
    #1 pix_valid = 1'b0;
  endtask

  task automatic do_row(input vec_t v, input int hold);
    exp_t e;
    int   lat, st, bad;
    logic [56:0] snap;
    send(v.pix, v.steps, v.thr, v.inj);
    e.cnt = v.cnt; e.ev = v.ev; e.idx = exp_idx; e.err = v.err;
    sb.push_back(e);
    exp_idx = exp_idx + 10'd1;
    if (hold > 0) res_ready = 1'b0;
    lat = 0; st = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (nrn_step_en) st++;
      if (res_valid) begin
        lat = k;
        break;
      end
    end
    chk("res_latency", 64'(lat), 64'(int'(v.steps) + 2 + DRAIN));
    chk("step_en_count", 64'(st), 64'(v.steps));
    if (hold > 0) begin
      bad  = 0;
      snap = out_vec();
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (out_vec() !== snap || !nrn_data_en || nrn_end_step || !res_valid) bad++;
      end
      chk("hold_stable", 64'(bad), 64'd0);
      res_ready = 1'b1;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk("res_count", 64'(res_count), 64'(e.cnt));
      chk("res_events", 64'(res_events), 64'(e.ev));
      chk("res_idx", 64'(res_idx), 64'(e.idx));
      chk("res_step_err", 64'(res_step_err), 64'(e.err));
    end
    @(negedge clk);
    chk("end_step_after_hs", 64'({nrn_end_step, nrn_data_en, res_valid}), 64'b100);
    @(negedge clk);
    chk("idle_after_end", 64'({pix_ready, nrn_end_step}), 64'b10);
  endtask

  task automatic gap_test();
    int st_cyc[$];
    int exp_gap[4] = '{2, 5, 8, 11};
    int lat2;
    @(negedge clk);
    pix_data = 8'd0; cfg_sp_steps = 8'd4; cfg_threshold = 8'd50; pix_valid2 = 1'b1;
    chk("gap_accept_ready", 64'(pix_ready2), 64'd1);
    @(posedge clk);
    #1 pix_valid2 = 1'b0;
    lat2 = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (se2) st_cyc.push_back(k);
      if (rv2) begin
        lat2 = k;
        break;
      end
    end
    chk("gap_step_count", 64'(st_cyc.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("gap_step_cycle", 64'((i < st_cyc.size()) ? st_cyc[i] : -1), 64'(exp_gap[i]));
    chk("gap_res_latency", 64'(lat2), 64'd14);
    repeat (3) @(negedge clk);
    chk("gap_back_idle", 64'(pix_ready2), 64'd1);
  endtask

  task automatic abort_test();
    int st;
    send(8'd0, 8'd64, 8'd50, 1'b0);
    exp_idx = exp_idx + 10'd1;
    st = 0;
    for (int k = 1; k <= 200 && st < 10; k++) begin
      @(negedge clk);
      if (nrn_step_en) st++;
    end
    chk("abort_at_step10", 64'(st), 64'd10);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_end_pulse", 64'({nrn_end_step, nrn_data_en, res_valid, nrn_step_en}), 64'b1000);
    @(negedge clk);
    chk("abort_idle", 64'({pix_ready, nrn_end_step, res_valid}), 64'b100);
  endtask

  task automatic async_reset_test();
    send(8'd0, 8'd64, 8'd50, 1'b0);
    repeat (6) @(negedge clk);
    chk("mid_run_data_en", 64'({nrn_data_en, pix_ready}), 64'b10);
    #1 reset_n = 1'b0;
    #1 chk("async_reset_outputs", 64'(out_vec()), 64'({1'b1, 56'd0}));
    sb.delete();
    exp_idx = '0;
    @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    rows[0] = '{8'd0,   DEFAULT_SP_STEPS, 8'd50,  1'b0, 8'd0,  8'd0,  1'b0};
    rows[1] = '{8'd255, 8'd64,  8'd10,  1'b0, 8'd64, 8'd1,  1'b0};
    rows[2] = '{8'd20,  8'd10,  8'd50,  1'b0, 8'd3,  8'd3,  1'b0};
    rows[3] = '{8'd200, 8'd0,   8'd10,  1'b0, 8'd0,  8'd0,  1'b0};
    rows[4] = '{8'd100, 8'd255, 8'd255, 1'b0, 8'd85, 8'd85, 1'b0};
    rows[5] = '{8'd50,  8'd7,   8'd50,  1'b0, 8'd7,  8'd1,  1'b0};
    rows[6] = '{8'd0,   8'd3,   8'd50,  1'b1, 8'd0,  8'd0,  1'b1};
    rows[7] = '{8'd200, 8'd1,   8'd10,  1'b0, 8'd1,  8'd1,  1'b0};

    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #10;
    chk("reset_outputs", 64'(out_vec()), 64'({1'b1, 56'd0}));
    chk("reset_gap_ready", 64'({pix_ready2, rv2, se2}), 64'b100);
    @(negedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 8; i++) do_row(rows[i], 0);
    do_row(rows[2], 20);
    gap_test();
    abort_test();
    do_row(rows[5], 0);
    async_reset_test();
    do_row(rows[2], 0);

    chk("clear_spike_timing", 64'(clr_bad), 64'd0);
    chk("clear_spike_seen", 64'(clr_seen > 0), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lif_step_controller.md
Name: lif_step_controller

Overview:
- Sequencer that drives the per-pixel flag interface of one LIF neuron: presents the pixel current, opens the evaluation window and issues time-step strobes.
- Acknowledges latched spikes, waits out the neuron's output pipeline, captures the final spike count and closes the window.
- Sits between the pixel stream (valid/ready) and the neuron. Emits one result per pixel on a valid/ready result port.

Parameters:
- STEP_GAP, 0, idle cycles inserted between consecutive step_en pulses (0 = one step per clock).
- DRAIN_CYCLES, 2, cycles waited after the last step_en before sampling nrn_spike_count. Must be >= 2.
- IDX_W, 10, width of the pixel index counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pixel available.
- pix_ready  out  1  controller can accept a pixel.
- pix_data  in  8  pixel intensity (input current).
- cfg_sp_steps  in  8  number of time steps per pixel. Sampled at pixel accept.
- cfg_threshold  in  8  neuron threshold. Sampled at pixel accept.
- abort  in  1  abandon the current pixel.
- nrn_input_current  out  8  latched pixel value.
- nrn_sp_steps  out  8  latched step count.
- nrn_threshold  out  8  latched threshold.
- nrn_data_en  out  1  evaluation window open.
- nrn_step_en  out  1  one-cycle step strobe.
- nrn_clear_spike  out  1  one-cycle spike acknowledge.
- nrn_end_step  out  1  one-cycle window close.
- nrn_spike_out  in  1  neuron latched spike.
- nrn_step  in  8  neuron step counter (starts at 1).
- nrn_spike_count  in  8  neuron spike count.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_count  out  8  captured nrn_spike_count.
- res_events  out  8  rising edges of nrn_spike_out seen in the window (saturating at 255).
- res_idx  out  IDX_W  pixel index (wraps at 2^IDX_W).
- res_step_err  out  1  nrn_step != sp_steps+1 at capture.

Behaviour:
- Reset (reset_n low, async):
  - State IDLE.
  - All outputs 0, except pix_ready = 1.
  - Latched config, counters and res_idx cleared to 0.
- All outputs are driven from registers.
- State machine:
  - IDLE: pix_ready = 1. On pix_valid & pix_ready, latch pix_data, cfg_sp_steps and cfg_threshold, clear the step and event counters, then go to LOAD.
  - LOAD (1 cycle): data_en = 1, step_en = 0. This gives the neuron a clean rising edge of data_en that is not coincident with a step.
    - sp_steps == 0: go to DRAIN.
    - Otherwise: go to RUN.
  - RUN: data_en held at 1.
    - step_en pulses once every STEP_GAP+1 cycles; the first pulse is in the first RUN cycle.
    - After sp_steps pulses, go to DRAIN.
  - DRAIN: data_en = 1, no step_en. Wait DRAIN_CYCLES cycles, then:
    - res_count <= nrn_spike_count.
    - res_step_err <= (nrn_step != sp_steps+1), with 8-bit wrap, so sp_steps = 255 expects 0.
    - Go to RESULT.
  - RESULT: res_valid = 1, data_en = 1. res_* held stable until res_valid & res_ready, then go to END.
  - END (1 cycle): end_step = 1, data_en = 0. res_idx increments. Go to IDLE.
- Spike acknowledge:
  - In LOAD, RUN and DRAIN, a rising edge of nrn_spike_out (versus its registered previous value) produces a one-cycle clear_spike in the next cycle.
  - The same edge increments the event counter.
  - Edges in RESULT/END are ignored.
- Timing with STEP_GAP = 0, sp_steps = N, accept at cycle 0:
  - LOAD at cycle 1.
  - step_en high for cycles 2..N+1.
  - res_valid first high at cycle N+2+DRAIN_CYCLES.
- abort: if high in LOAD, RUN, DRAIN or RESULT, go directly to END.
  - res_valid drops; no result is produced for that pixel.
  - end_step is still pulsed so the neuron is cleared.
  - res_idx increments.
  - Ignored in IDLE and END.
- Reset asserted mid-pixel: immediate return to the IDLE reset state; the neuron is reset by the shared system reset.
- pix_ready = 0 in every state except IDLE. Exactly one pixel is in flight.

Decomposition:
- Shared package lif_pkg:
  - State enum (IDLE, LOAD, RUN, DRAIN, RESULT, END).
  - Constants NRN_STEP_INIT = 1 and DEFAULT_SP_STEPS = 64.
  - Shared with the neuron bench.
- One natural sub-module, lif_step_timer:
  - Gap counter plus step counter.
  - Outputs step_en and last_step.
  - FSM remains in lif_step_controller.

Test Plan:
- pix_data = 0, sp_steps = 64, threshold = 50, real neuron, res_ready = 1 → step_en count 64, res_valid at cycle 68, res_count = 0, res_events = 0, res_step_err = 0, end_step one cycle after handshake.
- pix_data = 255, sp_steps = 64, threshold = 10 → res_count > 0, res_events >= 1, each clear_spike exactly one cycle after a spike_out rising edge, res_step_err = 0.
- STEP_GAP = 2, sp_steps = 4 → step_en at cycles 2, 5, 8, 11 after accept; res_valid at cycle 14.
- sp_steps = 0 → no step_en, res_count = 0, res_step_err = 0 (nrn_step = 1).
- res_ready held low 20 cycles → res_* stable, data_en stays 1, no end_step. Then three pixels back-to-back: res_idx = 0, 1, 2.
- abort at RUN step 10 → no res_valid, end_step pulsed, back in IDLE next cycle. Async reset_n low mid-RUN → all outputs 0 and pix_ready = 1 without waiting for a clock edge.
